pwm_axil_slave: RTL

PWM_AXIL_SLAVE -- requirements
Module: pwm_axil_slave

---
 rtl/pwm_axil_slave.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_axil_slave.sv
// AXI4-Lite slave exposing a shadowed PWM generator: CTRL, PERIOD, DUTY and a live COUNT.
// One write and one read may be in flight at a time; both channels run concurrently.
module pwm_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic                            pwm_out,
  output logic                            period_done
);

  localparam int DATA_W = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = DATA_W / 8;

  logic              ctrl_en;
  logic              ctrl_pol;
  logic [DATA_W-1:0] period_reg;
  logic [DATA_W-1:0] duty_reg;

  logic              aw_done;
  logic              w_done;
  logic [1:0]        waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic [DATA_W-1:0] active_period;
  logic [DATA_W-1:0] active_duty;
  logic [DATA_W-1:0] counter;
  logic              en_d;

  logic              rise_p0;
  logic [DATA_W-1:0] eff_period_p0;
  logic [DATA_W-1:0] eff_duty_p0;
  logic              last_p0;
  logic              active_p0;
  logic [DATA_W-1:0] rd_mux;

  logic unused;
  assign unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  assign BRESP = 2'b00;
  assign RRESP = 2'b00;

  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] cur,
                                                  input logic [DATA_W-1:0] wd,
                                                  input logic [STRB_W-1:0] st);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int i = 0; i < STRB_W; i++)
      if (st[i]) res[8*i +: 8] = wd[8*i +: 8];
    return res;
  endfunction

  // Write channel: independent AW/W capture, commit one cycle after both are held.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      AWREADY    <= 1'b0;
      WREADY     <= 1'b0;
      BVALID     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ctrl_en    <= 1'b0;
      ctrl_pol   <= 1'b0;
      period_reg <= '0;
      duty_reg   <= '0;
    end else begin
      AWREADY <= AWVALID && !AWREADY && !aw_done && !BVALID;
      WREADY  <= WVALID && !WREADY && !w_done && !BVALID;
      if (AWREADY && AWVALID) begin
        waddr_q <= AWADDR[3:2];
        aw_done <= 1'b1;
      end
      if (WREADY && WVALID) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
        w_done  <= 1'b1;
      end
      if (aw_done && w_done && !BVALID) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        BVALID  <= 1'b1;
        case (waddr_q)
          2'd0: begin
            if (wstrb_q[0]) begin
              ctrl_en  <= wdata_q[0];
              ctrl_pol <= wdata_q[1];
            end
          end
          2'd1:    period_reg <= apply_strb(period_reg, wdata_q, wstrb_q);
          2'd2:    duty_reg   <= apply_strb(duty_reg, wdata_q, wstrb_q);
          default: ;
        endcase
      end else if (BVALID && BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = counter;
    case (ARADDR[3:2])
      2'd0:    rd_mux = {{(DATA_W-2){1'b0}}, ctrl_pol, ctrl_en};
      2'd1:    rd_mux = period_reg;
      2'd2:    rd_mux = duty_reg;
      default: rd_mux = counter;
    endcase
  end

  // Read channel: data captured at the AR handshake, held until RREADY.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
    end else begin
      ARREADY <= ARVALID && !ARREADY && !RVALID;
      if (ARREADY && ARVALID) begin
        RVALID <= 1'b1;
        RDATA  <= rd_mux;
      end else if (RVALID && RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

  // On the enable edge the shadows are stale, so the live registers drive that first cycle.
  always_comb begin
    rise_p0       = ctrl_en && !en_d;
    eff_period_p0 = rise_p0 ? period_reg : active_period;
    eff_duty_p0   = rise_p0 ? duty_reg : active_duty;
    last_p0       = ctrl_en && (counter == eff_period_p0);
    active_p0     = ctrl_en && (counter < eff_duty_p0);
  end

  // PWM stage p0 -> p1: counter/shadows advance, waveform and period pulse registered.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      en_d          <= 1'b0;
      active_period <= '0;
      active_duty   <= '0;
      counter       <= '0;
      pwm_out       <= 1'b0;
      period_done   <= 1'b0;
    end else begin
      en_d <= ctrl_en;
      if (rise_p0 || last_p0) begin
        active_period <= period_reg;
        active_duty   <= duty_reg;
      end
      if (!ctrl_en || last_p0) counter <= '0;
      else                     counter <= counter + 1'b1;
      pwm_out     <= active_p0 ^ ctrl_pol;
      period_done <= last_p0;
    end
  end

endmodule
